// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit scheduler.
package uart_pkg;

    localparam int UART_DATA_WIDTH  = 8;
    localparam int UART_CNT_WIDTH   = 16;
    localparam int UART_ACK_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        START     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5,
        FLUSH     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler.sv
// Drains a byte FIFO into a UART transmitter one byte at a time, with
// acknowledge timeout, flush support and sent/dropped byte counters.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int CNT_WIDTH   = UART_CNT_WIDTH,
    parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  sched_busy,
    output logic                  ack_err,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int TO_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);

    sched_state_t    state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;

    assign timeout = (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // A transmitter that answers on the very cycle the timeout expires wins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (flush && !fifo_empty)                    state_nxt = FLUSH;
                else if (enable && !fifo_empty && !tx_busy)  state_nxt = FETCH;
            end
            FETCH:     state_nxt = LATCH;
            LATCH:     state_nxt = START;
            START:     state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy)      state_nxt = WAIT_DONE;
                else if (timeout) state_nxt = IDLE;
            end
            WAIT_DONE: if (!tx_busy)  state_nxt = IDLE;
            FLUSH:     if (fifo_empty) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Read strobes are qualified by fifo_empty so an empty FIFO is never read.
    always_comb begin
        fifo_ren   = 1'b0;
        tx_start   = 1'b0;
        ack_err    = 1'b0;
        sched_busy = (state != IDLE);
        unique case (state)
            FETCH:    fifo_ren = !fifo_empty;
            START:    tx_start = 1'b1;
            WAIT_ACK: ack_err  = timeout && !tx_busy;
            FLUSH:    fifo_ren = !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt   <= '0;
            tx_data  <= '0;
            byte_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            to_cnt <= (state == WAIT_ACK) ? to_cnt + TO_W'(1) : '0;
            if (state == LATCH)
                tx_data <= fifo_dout;
            if (state == WAIT_DONE && !tx_busy)
                byte_cnt <= byte_cnt + CNT_WIDTH'(1);
            if (state == FLUSH && !fifo_empty)
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: FIFO and transmitter models drive the scheduler, a monitor
// checks each cycle against a transaction-level expectation.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0, flush = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_ren, tx_busy = 1'b0, tx_start, sched_busy, ack_err;
    logic [7:0]  tx_data;
    logic [15:0] byte_cnt, drop_cnt;
    logic        fifo_ren_w, tx_start_w, sched_busy_w, ack_err_w;
    logic [7:0]  tx_data_w;
    logic [1:0]  byte_cnt_w, drop_cnt_w;

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .sched_busy(sched_busy), .ack_err(ack_err),
        .byte_cnt(byte_cnt), .drop_cnt(drop_cnt)
    );

    uart_tx_scheduler #(.CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_ren(fifo_ren_w),
        .tx_busy(tx_busy), .tx_start(tx_start_w), .tx_data(tx_data_w),
        .sched_busy(sched_busy_w), .ack_err(ack_err_w),
        .byte_cnt(byte_cnt_w), .drop_cnt(drop_cnt_w)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    endtask

    // FIFO model: initial block writes, posedge process reads.
    logic [7:0] fmem [0:63];
    int fwr = 0;
    int frd = 0;
    assign fifo_empty = (fwr == frd);

    always @(posedge clk) begin
        if (fifo_ren && !fifo_empty) begin
            fifo_dout <= fmem[frd];
            frd       <= frd + 1;
        end
    end

    // Expected transmitted bytes, in order.
    logic [7:0] exp_mem [0:63];
    int exp_wr = 0;
    int exp_rd = 0;

    task automatic push(input logic [7:0] d, input bit sent);
        fmem[fwr] = d;
        fwr++;
        if (sent) begin
            exp_mem[exp_wr] = d;
            exp_wr++;
        end
    endtask

    // Transmitter: busy from the cycle after tx_start for tx_len cycles.
    // A byte counts as sent on the edge after busy drops.
    int tx_len   = 10;
    bit tx_never = 1'b0;
    int tx_left  = 0;
    bit done_pend = 1'b0;
    int exp_byte = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_busy   <= 1'b0;
            tx_left   <= 0;
            done_pend <= 1'b0;
            exp_byte  <= 0;
        end else begin
            if (done_pend) exp_byte <= exp_byte + 1;
            done_pend <= tx_busy && (tx_left == 0);
            if (tx_busy) begin
                if (tx_left == 0) tx_busy <= 1'b0;
                else              tx_left <= tx_left - 1;
            end else if (tx_start && !tx_never) begin
                tx_busy <= 1'b1;
                tx_left <= tx_len - 1;
            end
        end
    end

    // Per-cycle monitor.
    bit   exp_to = 1'b0;
    int   cyc = 0, n_start = 0, n_ren = 0, n_ack = 0, ren_since = 0;
    int   last_start = 0, first_ren = 0, last_ren = 0;
    logic prev_start = 1'b0;
    logic [1:0] prev_w = 2'd0;
    logic [1:0] wlog [$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            n_start = 0; n_ren = 0; n_ack = 0; ren_since = 0;
            prev_start = 1'b0; prev_w = 2'd0;
            wlog.delete();
        end else begin
            chk("ren_while_empty", fifo_ren && fifo_empty, 0);
            chk("byte_cnt", byte_cnt, exp_byte[15:0]);
            chk("byte_cnt_w", byte_cnt_w, exp_byte[1:0]);
            chk("lockstep_w", {fifo_ren_w, tx_start_w, ack_err_w, sched_busy_w, tx_data_w, drop_cnt_w},
                              {fifo_ren, tx_start, ack_err, sched_busy, tx_data, drop_cnt[1:0]});
            if (fifo_ren) begin
                if (n_ren == 0) first_ren = cyc;
                last_ren = cyc;
                n_ren++;
                ren_since++;
            end
            if (tx_start) begin
                chk("start_width", prev_start, 0);
                chk("ren_per_byte", ren_since, 1);
                if (exp_rd < exp_wr) begin
                    chk("tx_data", tx_data, exp_mem[exp_rd]);
                    exp_rd++;
                end else chk("unexpected_start", 1, 0);
                ren_since  = 0;
                last_start = cyc;
                n_start++;
            end
            if (ack_err) begin
                chk("ack_expected", exp_to, 1);
                chk("ack_delay", cyc - last_start, 16);
                n_ack++;
            end
            if (byte_cnt_w != prev_w) begin
                wlog.push_back(byte_cnt_w);
                prev_w = byte_cnt_w;
            end
            prev_start = tx_start;
        end
    end

    task automatic do_reset();
        enable = 1'b0;
        flush  = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        repeat (2) @(negedge clk);
        while ((sched_busy || !fifo_empty) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("wait_bound", k < maxc, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] wexp [0:4];
        int k;
        wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;

        #12;
        chk("rst_ctrl", {fifo_ren, tx_start, ack_err, sched_busy}, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_cnts", {byte_cnt, drop_cnt}, 0);
        @(negedge clk); rst = 1'b1;

        // Single byte
        push(8'hA5, 1); enable = 1'b1;
        wait_done(100);
        chk("single_byte_cnt", byte_cnt, 1);
        chk("single_tx_data", tx_data, 8'hA5);
        chk("single_starts", n_start, 1);
        chk("single_rens", n_ren, 1);
        chk("single_idle", sched_busy, 0);

        // Burst of three
        do_reset();
        push(8'h01, 1); push(8'h02, 1); push(8'h03, 1);
        enable = 1'b1;
        wait_done(300);
        chk("burst_byte_cnt", byte_cnt, 3);
        chk("burst_starts", n_start, 3);
        chk("burst_rens", n_ren, 3);
        chk("burst_tx_data", tx_data, 8'h03);

        // Flush beats enable
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 0);
        @(negedge clk); enable = 1'b1; flush = 1'b1;
        wait_done(100);
        chk("flush_drop_cnt", drop_cnt, 5);
        chk("flush_rens", n_ren, 5);
        chk("flush_ren_span", last_ren - first_ren + 1, 5);
        chk("flush_starts", n_start, 0);
        chk("flush_byte_cnt", byte_cnt, 0);
        chk("flush_idle", sched_busy, 0);

        // Acknowledge timeout
        do_reset();
        tx_never = 1'b1; exp_to = 1'b1;
        push(8'h5A, 1); enable = 1'b1;
        wait_done(100);
        chk("to_acks", n_ack, 1);
        chk("to_starts", n_start, 1);
        chk("to_byte_cnt", byte_cnt, 0);
        chk("to_idle", sched_busy, 0);
        tx_never = 1'b0; exp_to = 1'b0;

        // Reset during WAIT_DONE
        do_reset();
        push(8'h77, 1); enable = 1'b1;
        k = 0;
        while (!tx_busy && k < 50) begin @(negedge clk); k++; end
        chk("mid_reach_busy", tx_busy, 1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {fifo_ren, tx_start, ack_err, sched_busy}, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_cnts", {byte_cnt, drop_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        chk("mid_no_start", n_start, 0);
        chk("mid_idle", sched_busy, 0);

        // Counter wrap on the 2-bit instance
        do_reset();
        tx_len = 3;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 1);
        enable = 1'b1;
        wait_done(500);
        chk("wrap_len", wlog.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < wlog.size()) chk("wrap_seq", wlog[i], wexp[i]);
        chk("wrap_main_cnt", byte_cnt, 5);
        chk("wrap_w_cnt", byte_cnt_w, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
